// File: rtl/gng_pkg.sv
// Shared definitions for the Gaussian noise generator sequencer: state codes,
// default watchdog limit and datapath sample width.
package gng_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAND    = 3'd1,
    LOG_COS = 3'd2,
    SQRT    = 3'd3,
    MULT    = 3'd4,
    HOLD    = 3'd5,
    ERR     = 3'd6
  } gng_state_t;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int SAMPLE_W        = 16;

  // States that wait on an external unit and therefore can hang.
  function automatic logic is_watched(input gng_state_t s);
    return s inside {RAND, LOG_COS, SQRT, MULT};
  endfunction

endpackage

// File: rtl/gng_watchdog.sv
// Per-stage watchdog: counts cycles spent in a watched stage and flags the
// cycle on which the stage has used its last allowed cycle.
module gng_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic reload,
  input  logic run,
  output logic trip
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || reload) begin
      count <= '0;
    end else if (run && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign trip = run && (count == LAST);

endmodule

// File: rtl/gng_sequencer.sv
// Top-level controller for the noise datapath: walks RAND -> LOG_COS -> SQRT
// -> MULT -> HOLD with start/done handshakes and a watchdog on each unit stage.
module gng_sequencer
  import gng_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             rand_gen,
  input  logic             valid_u0,
  input  logic             valid_u1,
  output logic             log_start,
  output logic             cos_start,
  input  logic             log_done,
  input  logic             cos_done,
  output logic             sqrt_start,
  input  logic             sqrt_done,
  output logic             mult_start,
  input  logic             mult_done,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             timeout_err,
  output logic [2:0]       err_state,
  input  logic             clear_err,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [2:0]       state_o
);

  // Downstream handshake: a pair transfers on any cycle where sample_valid
  // and sample_ready are both high; sample_valid never drops before that.

  gng_state_t state;
  gng_state_t next_state;

  logic u0_seen, u1_seen, log_seen, cos_seen, sqrt_seen;
  logic u0_hit, u1_hit, log_hit, cos_hit, sqrt_hit;
  logic rand_exit, sqrt_exit;
  logic entering;
  logic watched;
  logic trip;

  logic rand_gen_nxt, log_start_nxt, cos_start_nxt;
  logic sqrt_start_nxt, mult_start_nxt, sample_valid_nxt;

  // A done seen this cycle counts just like one latched earlier.
  assign u0_hit   = u0_seen   | valid_u0;
  assign u1_hit   = u1_seen   | valid_u1;
  assign log_hit  = log_seen  | log_done;
  assign cos_hit  = cos_seen  | cos_done;
  assign sqrt_hit = sqrt_seen | sqrt_done;

  assign rand_exit = u0_hit & u1_hit;
  assign sqrt_exit = sqrt_hit & cos_hit;

  assign watched  = is_watched(state);
  assign entering = (next_state != state);

  gng_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .reload(entering),
    .run   (watched),
    .trip  (trip)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Exit conditions are tested before the trip so a late done still wins.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable && !timeout_err) next_state = RAND;
      RAND: begin
        if (rand_exit)   next_state = LOG_COS;
        else if (trip)   next_state = ERR;
      end
      LOG_COS: begin
        if (log_hit)     next_state = SQRT;
        else if (trip)   next_state = ERR;
      end
      SQRT: begin
        if (sqrt_exit)   next_state = MULT;
        else if (trip)   next_state = ERR;
      end
      MULT: begin
        if (mult_done)   next_state = HOLD;
        else if (trip)   next_state = ERR;
      end
      HOLD:    if (sample_ready) next_state = enable ? RAND : IDLE;
      ERR:     if (clear_err)    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rand_gen_nxt     = (next_state == RAND);
    log_start_nxt    = (next_state == LOG_COS) && entering;
    cos_start_nxt    = (next_state == LOG_COS) && entering;
    sqrt_start_nxt   = (next_state == SQRT)    && entering;
    mult_start_nxt   = (next_state == MULT)    && entering;
    sample_valid_nxt = (next_state == HOLD);
  end

  // cos_seen alone survives LOG_COS -> SQRT: cosine may outlast the log unit.
  always_ff @(posedge clk) begin
    if (reset) begin
      u0_seen   <= 1'b0;
      u1_seen   <= 1'b0;
      log_seen  <= 1'b0;
      cos_seen  <= 1'b0;
      sqrt_seen <= 1'b0;
    end else if (entering) begin
      u0_seen   <= 1'b0;
      u1_seen   <= 1'b0;
      log_seen  <= 1'b0;
      cos_seen  <= (state == LOG_COS) && (next_state == SQRT) && cos_hit;
      sqrt_seen <= 1'b0;
    end else begin
      if (state == RAND) begin
        u0_seen <= u0_hit;
        u1_seen <= u1_hit;
      end
      if (state == LOG_COS) begin
        log_seen <= log_hit;
        cos_seen <= cos_hit;
      end
      if (state == SQRT) begin
        sqrt_seen <= sqrt_hit;
        cos_seen  <= cos_hit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rand_gen     <= 1'b0;
      log_start    <= 1'b0;
      cos_start    <= 1'b0;
      sqrt_start   <= 1'b0;
      mult_start   <= 1'b0;
      sample_valid <= 1'b0;
      sample_cnt   <= '0;
      timeout_err  <= 1'b0;
      err_state    <= 3'd0;
    end else begin
      rand_gen     <= rand_gen_nxt;
      log_start    <= log_start_nxt;
      cos_start    <= cos_start_nxt;
      sqrt_start   <= sqrt_start_nxt;
      mult_start   <= mult_start_nxt;
      sample_valid <= sample_valid_nxt;
      if ((state == HOLD) && sample_ready) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
      end
      if ((next_state == ERR) && (state != ERR)) begin
        timeout_err <= 1'b1;
        err_state   <= state;
      end else if ((state == ERR) && (next_state == IDLE)) begin
        timeout_err <= 1'b0;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_gng_sequencer.sv
// Bench for gng_sequencer: two instances (long and short watchdog / counter
// widths) driven by shared, reactive unit models and checked against stage-length predictions.
module tb_gng_sequencer;

  typedef struct {
    int u0; int u1; int lg; int cs; int sq; int mu; int rd; int jk;
  } cfg_t;

  typedef struct {
    cfg_t c;
    int r; int lc; int sq; int mu; int ho;
  } vec_t;

  logic clk = 1'b0;
  logic reset, enable, clear_err;
  logic valid_u0, valid_u1, log_done, cos_done, sqrt_done, mult_done, sample_ready;

  logic rand_gen_a, log_start_a, cos_start_a, sqrt_start_a, mult_start_a;
  logic sample_valid_a, timeout_err_a;
  logic [2:0] err_state_a, state_o_a;
  logic [15:0] sample_cnt_a;

  logic rand_gen_b, log_start_b, cos_start_b, sqrt_start_b, mult_start_b;
  logic sample_valid_b, timeout_err_b;
  logic [2:0] err_state_b, state_o_b;
  logic [1:0] sample_cnt_b;

  int checks = 0;
  int failures = 0;
  int model_cnt = 0;

  cfg_t cfg_q[$];
  logic [15:0] exp_q[$];
  vec_t vecs[8];

  cfg_t cur;
  int c_u0, c_u1, c_lg, c_cs, c_sq, c_mu, c_rd;
  logic prev_rand, prev_valid;

  gng_sequencer #(.TIMEOUT_CYCLES(255), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .rand_gen(rand_gen_a),
    .valid_u0(valid_u0), .valid_u1(valid_u1),
    .log_start(log_start_a), .cos_start(cos_start_a),
    .log_done(log_done), .cos_done(cos_done),
    .sqrt_start(sqrt_start_a), .sqrt_done(sqrt_done),
    .mult_start(mult_start_a), .mult_done(mult_done),
    .sample_valid(sample_valid_a), .sample_ready(sample_ready),
    .timeout_err(timeout_err_a), .err_state(err_state_a), .clear_err(clear_err),
    .sample_cnt(sample_cnt_a), .state_o(state_o_a)
  );

  gng_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .rand_gen(rand_gen_b),
    .valid_u0(valid_u0), .valid_u1(valid_u1),
    .log_start(log_start_b), .cos_start(cos_start_b),
    .log_done(log_done), .cos_done(cos_done),
    .sqrt_start(sqrt_start_b), .sqrt_done(sqrt_done),
    .mult_start(mult_start_b), .mult_done(mult_done),
    .sample_valid(sample_valid_b), .sample_ready(sample_ready),
    .timeout_err(timeout_err_b), .err_state(err_state_b), .clear_err(clear_err),
    .sample_cnt(sample_cnt_b), .state_o(state_o_b)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench time limit reached");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] outs_a();
    return {3'b0, rand_gen_a, log_start_a, cos_start_a, sqrt_start_a, mult_start_a,
            sample_valid_a, timeout_err_a, err_state_a, state_o_a, sample_cnt_a};
  endfunction

  function automatic logic [31:0] outs_b();
    return {17'b0, rand_gen_b, log_start_b, cos_start_b, sqrt_start_b, mult_start_b,
            sample_valid_b, timeout_err_b, err_state_b, state_o_b, sample_cnt_b};
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Unit models: each unit answers its start a configured number of cycles
  // later (0 = same cycle as the start), as a single-cycle pulse.
  task automatic respond();
    valid_u0 = 1'b0; valid_u1 = 1'b0; log_done = 1'b0; cos_done = 1'b0;
    sqrt_done = 1'b0; mult_done = 1'b0; sample_ready = 1'b0;
    if (rand_gen_a && !prev_rand) begin
      if (cfg_q.size() > 0) cur = cfg_q.pop_front();
      else cur = '{default: 0};
      c_u0 = cur.u0;
      c_u1 = cur.u1;
      if (cur.jk != 0) begin
        log_done = 1'b1; cos_done = 1'b1; sqrt_done = 1'b1; mult_done = 1'b1;
      end
    end
    if (log_start_a) begin c_lg = cur.lg; c_cs = cur.cs; end
    if (sqrt_start_a) c_sq = cur.sq;
    if (mult_start_a) c_mu = cur.mu;
    if (sample_valid_a && !prev_valid) c_rd = cur.rd;
    if (c_u0 == 0) valid_u0 = 1'b1;
    if (c_u1 == 0) valid_u1 = 1'b1;
    if (c_lg == 0) log_done = 1'b1;
    if (c_cs == 0) cos_done = 1'b1;
    if (c_sq == 0) sqrt_done = 1'b1;
    if (c_mu == 0) mult_done = 1'b1;
    if (c_rd == 0) sample_ready = 1'b1;
    if (c_u0 >= 0) c_u0--;
    if (c_u1 >= 0) c_u1--;
    if (c_lg >= 0) c_lg--;
    if (c_cs >= 0) c_cs--;
    if (c_sq >= 0) c_sq--;
    if (c_mu >= 0) c_mu--;
    if (c_rd >= 0) c_rd--;
    prev_rand = rand_gen_a;
    prev_valid = sample_valid_a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    respond();
  endtask

  task automatic reset_all();
    reset = 1'b1; enable = 1'b0; clear_err = 1'b0;
    cfg_q.delete(); exp_q.delete(); model_cnt = 0;
    c_u0 = -1; c_u1 = -1; c_lg = -1; c_cs = -1; c_sq = -1; c_mu = -1; c_rd = -1;
    prev_rand = 1'b0; prev_valid = 1'b0;
    tick();
    tick();
    check("reset_outs_a", outs_a(), 32'd0);
    check("reset_outs_b", outs_b(), 32'd0);
    reset = 1'b0;
  endtask

  task automatic wait_state(input bit on_b, input int st, input string nm);
    int n = 0;
    while (int'(on_b ? state_o_b : state_o_a) != st && n < 100) begin
      n++;
      tick();
    end
    check(nm, on_b ? state_o_b : state_o_a, st);
  endtask

  // Count how long dut_a stays in one state plus its marker output activity.
  task automatic measure(input int st, input int exp_len, input string nm, input bit sync_b);
    int n = 0, marks = 0, cos_marks = 0, desync = 0;
    while (int'(state_o_a) == st && n < 1000) begin
      case (st)
        1: marks += int'(rand_gen_a);
        2: begin marks += int'(log_start_a); cos_marks += int'(cos_start_a); end
        3: marks += int'(sqrt_start_a);
        4: marks += int'(mult_start_a);
        default: marks += int'(sample_valid_a);
      endcase
      if (sync_b && (state_o_b != state_o_a)) desync++;
      n++;
      tick();
    end
    check({nm, "_len"}, n, exp_len);
    check({nm, "_marks"}, marks, (st == 1 || st == 5) ? n : 1);
    if (st == 2) check({nm, "_cos_start"}, cos_marks, 1);
    if (sync_b) check({nm, "_b_sync"}, desync, 0);
  endtask

  task automatic run_sample(input int r, input int lc, input int sq, input int mu,
                            input int ho, input string tag, input bit sync_b);
    measure(1, r, {tag, "_rand"}, sync_b);
    measure(2, lc, {tag, "_logcos"}, sync_b);
    measure(3, sq, {tag, "_sqrt"}, sync_b);
    measure(4, mu, {tag, "_mult"}, sync_b);
    measure(5, ho, {tag, "_hold"}, sync_b);
    model_cnt++;
    check({tag, "_cnt_a"}, sample_cnt_a, model_cnt % 65536);
    if (sync_b) begin
      check({tag, "_cnt_b"}, sample_cnt_b, model_cnt % 4);
      check({tag, "_no_err_b"}, timeout_err_b, 0);
    end
  endtask

  initial begin
    int seq_err;
    int n;
    int l[5];
    cfg_t c;

    //          u0 u1 lg cs sq mu rd jk     rand lc sqrt mult hold
    vecs[0] = '{'{0, 0, 0, 0, 0, 0, 0, 0},  1, 1, 1, 1, 1};
    vecs[1] = '{'{2, 7, 0, 0, 0, 0, 0, 1},  8, 1, 1, 1, 1};
    vecs[2] = '{'{0, 0, 3, 1, 0, 0, 0, 0},  1, 4, 1, 1, 1};
    vecs[3] = '{'{0, 0, 0, 5, 1, 0, 0, 0},  1, 1, 5, 1, 1};
    vecs[4] = '{'{0, 0, 0, 0, 0, 4, 2, 1},  1, 1, 1, 5, 3};
    vecs[5] = '{'{7, 0, 7, 7, 0, 0, 0, 0},  8, 8, 1, 1, 1};
    vecs[6] = '{'{0, 0, 0, 0, 7, 0, 0, 0},  1, 1, 8, 1, 1};
    vecs[7] = '{'{3, 3, 2, 6, 2, 2, 5, 1},  4, 3, 4, 3, 6};

    valid_u0 = 0; valid_u1 = 0; log_done = 0; cos_done = 0;
    sqrt_done = 0; mult_done = 0; sample_ready = 0;

    // Minimum loop with single-cycle units: RAND..HOLD repeating every 5 cycles.
    reset_all();
    enable = 1'b1;
    wait_state(0, 1, "loop_first_rand");
    seq_err = 0;
    for (int i = 0; i < 20; i++) begin
      if (int'(state_o_a) != 1 + (i % 5)) seq_err++;
      if (log_start_a != cos_start_a) seq_err++;
      tick();
    end
    check("loop_sequence", seq_err, 0);
    check("loop_cnt_after_20", sample_cnt_a, 4);

    // Directed delay table.
    reset_all();
    for (int i = 0; i < 8; i++) cfg_q.push_back(vecs[i].c);
    enable = 1'b1;
    wait_state(0, 1, "table_first_rand");
    for (int i = 0; i < 8; i++) begin
      run_sample(vecs[i].r, vecs[i].lc, vecs[i].sq, vecs[i].mu, vecs[i].ho,
                 $sformatf("vec%0d", i), 1'b1);
    end

    // Random delays, every stage within the short watchdog limit.
    reset_all();
    for (int s = 0; s < 40; s++) begin
      c.u0 = $urandom_range(0, 7); c.u1 = $urandom_range(0, 7);
      c.lg = $urandom_range(0, 7); c.cs = $urandom_range(0, 7);
      c.sq = $urandom_range(0, 7); c.mu = $urandom_range(0, 7);
      c.rd = $urandom_range(0, 12); c.jk = $urandom_range(0, 1);
      cfg_q.push_back(c);
      exp_q.push_back(16'(max2(c.u0, c.u1) + 1));
      exp_q.push_back(16'(c.lg + 1));
      exp_q.push_back(16'(max2(c.sq, max2(c.cs - c.lg - 1, 0)) + 1));
      exp_q.push_back(16'(c.mu + 1));
      exp_q.push_back(16'(c.rd + 1));
    end
    enable = 1'b1;
    wait_state(0, 1, "rnd_first_rand");
    for (int s = 0; s < 40; s++) begin
      for (int k = 0; k < 5; k++) l[k] = int'(exp_q.pop_front());
      run_sample(l[0], l[1], l[2], l[3], l[4], $sformatf("rnd%0d", s), 1'b1);
    end

    // Cosine finishing 10 cycles after sqrt: SQRT waits, one mult_start.
    reset_all();
    cfg_q.push_back('{0, 0, 0, 11, 0, 0, 0, 0});
    enable = 1'b1;
    wait_state(0, 1, "late_first_rand");
    run_sample(1, 1, 11, 1, 1, "late_cos", 1'b0);

    // Backpressure: 500 cycles with ready low, watchdog must stay quiet.
    reset_all();
    cfg_q.push_back('{0, 0, 0, 0, 0, 0, 500, 0});
    enable = 1'b1;
    wait_state(0, 1, "bp_first_rand");
    run_sample(1, 1, 1, 1, 501, "bp", 1'b1);
    check("bp_no_err_a", timeout_err_a, 0);

    // Hung log unit on the short-watchdog instance.
    reset_all();
    cfg_q.push_back('{0, 0, 1000, 0, 0, 0, 0, 0});
    enable = 1'b1;
    wait_state(1, 2, "to_enter_logcos");
    n = 0;
    while (int'(state_o_b) == 2 && n < 50) begin
      n++;
      tick();
    end
    check("to_logcos_cycles", n, 8);
    check("to_state_err", state_o_b, 6);
    check("to_timeout_err", timeout_err_b, 1);
    check("to_err_state", err_state_b, 2);
    check("to_rand_gen_off", rand_gen_b, 0);
    for (int i = 0; i < 3; i++) tick();
    check("to_err_sticky", {timeout_err_b, state_o_b}, {1'b1, 3'd6});
    check("to_no_start_in_err", {log_start_b, sqrt_start_b, mult_start_b, sample_valid_b}, 0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("to_clear_to_idle", state_o_b, 0);
    check("to_clear_flag", timeout_err_b, 0);
    check("to_clear_ignored_a", state_o_a, 2);
    check("to_long_no_err_a", timeout_err_a, 0);
    tick();
    check("to_idle_to_rand", state_o_b, 1);

    // Reset while in SQRT after two completed samples.
    reset_all();
    cfg_q.push_back('{0, 0, 0, 0, 0, 0, 0, 0});
    cfg_q.push_back('{0, 0, 0, 0, 0, 0, 0, 0});
    cfg_q.push_back('{0, 0, 0, 0, 5, 0, 0, 0});
    enable = 1'b1;
    wait_state(0, 1, "mid_first_rand");
    run_sample(1, 1, 1, 1, 1, "mid_pre0", 1'b1);
    run_sample(1, 1, 1, 1, 1, "mid_pre1", 1'b1);
    wait_state(0, 3, "mid_in_sqrt");
    tick();
    reset = 1'b1;
    tick();
    check("mid_reset_outs_a", outs_a(), 32'd0);
    check("mid_reset_outs_b", outs_b(), 32'd0);
    reset = 1'b0;

    // enable dropping mid-sample: sample completes, then IDLE.
    reset_all();
    cfg_q.push_back('{0, 0, 0, 0, 0, 3, 0, 0});
    enable = 1'b1;
    wait_state(0, 3, "en_in_sqrt");
    enable = 1'b0;
    measure(3, 1, "en_sqrt", 1'b1);
    measure(4, 4, "en_mult", 1'b1);
    measure(5, 1, "en_hold", 1'b1);
    check("en_to_idle", state_o_a, 0);
    for (int i = 0; i < 3; i++) tick();
    check("en_stay_idle", {state_o_a, state_o_b}, 0);
    check("en_cnt", sample_cnt_a, 1);

    // Narrow counter wraps: 5 samples with a 2-bit counter reads 1.
    reset_all();
    for (int i = 0; i < 5; i++) cfg_q.push_back('{0, 0, 0, 0, 0, 0, 0, 0});
    enable = 1'b1;
    wait_state(0, 1, "wrap_first_rand");
    for (int i = 0; i < 5; i++) run_sample(1, 1, 1, 1, 1, $sformatf("wrap%0d", i), 1'b1);
    check("wrap_cnt_b", sample_cnt_b, 1);
    check("wrap_cnt_a", sample_cnt_a, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gng_sequencer.md
Name: gng_sequencer

Overview:
Central controller for the Gaussian noise generator datapath. It sequences the two Tausworthe generators, the log and cosine units (in parallel), the sqrt unit and the final multiplier through start/done handshakes. It presents each finished sample pair to downstream logic with a valid/ready handshake. A per-stage watchdog detects hung units and parks the sequencer in an error state until software clears it.

Parameters:
TIMEOUT_CYCLES, 255, max cycles allowed in any watched stage before the error trips (must be ≥2)
CNT_W, 16, width of produced-sample counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  level; run continuously while high
rand_gen  out  1  level enable to both taus_gen instances
valid_u0  in  1  taus_gen u0 output valid
valid_u1  in  1  taus_gen u1 output valid
log_start  out  1  one-cycle start pulse to log_unit
cos_start  out  1  one-cycle start pulse to cosine_unit
log_done  in  1  log_unit done
cos_done  in  1  cosine_unit done
sqrt_start  out  1  one-cycle start pulse to sqrt_unit
sqrt_done  in  1  sqrt_unit done
mult_start  out  1  one-cycle pulse to load x0/x1 multiply
mult_done  in  1  multiplier done
sample_valid  out  1  x0/x1 pair available downstream
sample_ready  in  1  downstream accepts pair
timeout_err  out  1  sticky watchdog error
err_state  out  3  state encoding captured at timeout
clear_err  in  1  clears error, returns to IDLE
sample_cnt  out  CNT_W  accepted samples, wraps at 2^CNT_W
state_o  out  3  current state, debug

Behaviour:
- Reset: state=IDLE. All outputs are 0, including sample_cnt, timeout_err and err_state. Sticky flags and watchdog are cleared. Reset mid-operation aborts the current sample at the next edge.
- All outputs are registered. Start pulses are high only in the first cycle of their state.
- IDLE(0): if enable and !timeout_err -> RAND.
- RAND(1): rand_gen=1.
  - u0_seen/u1_seen are sticky; valid_u0 and valid_u1 may arrive in different cycles.
  - When both are seen (including the current cycle) -> LOG_COS. Flags clear on exit.
- LOG_COS(2): log_start=cos_start=1 in the entry cycle.
  - log_seen and cos_seen are sticky.
  - A done sampled in the entry cycle itself is accepted.
  - When log_seen -> SQRT. cos_seen is retained.
- SQRT(3): sqrt_start pulse on entry. Exit to MULT when sqrt_seen and cos_seen; cosine may finish after sqrt.
- MULT(4): mult_start pulse on entry. mult_done -> HOLD.
- HOLD(5): sample_valid=1.
  - On sample_ready: sample_cnt+1; all done flags clear; then enable -> RAND, !enable -> IDLE.
  - Zero-wait accept: ready high on the first HOLD cycle means exactly 1 HOLD cycle.
- ERR(6): entered from RAND, LOG_COS, SQRT or MULT when the watchdog reaches TIMEOUT_CYCLES.
  - Sets timeout_err=1 and err_state=the state that hung.
  - No start pulses, rand_gen=0, sample_valid=0.
  - clear_err -> IDLE next cycle, and timeout_err clears. clear_err in any other state is ignored.
- Watchdog:
  - Reloads to 0 on every state entry and increments each cycle in a watched state.
  - Trips on the cycle count==TIMEOUT_CYCLES-1 if the exit condition is false that cycle.
  - An exit condition and the trip in the same cycle: the exit wins.
  - HOLD and IDLE are unwatched; backpressure is unlimited.
- enable falling mid-sample: the current sample completes through HOLD, then IDLE. enable is sampled only in IDLE and at HOLD exit.
- Done/valid inputs arriving in non-matching states are ignored and not latched.
- Minimum loop with all units single-cycle and ready=1: RAND, LOG_COS, SQRT, MULT, HOLD = 5 cycles per sample.

Decomposition:
- Shared package gng_pkg holds:
  - state encodings IDLE..ERR as 3-bit localparams
  - default TIMEOUT_CYCLES
  - the sample-pair width (16)
- One natural sub-module: gng_watchdog (counter with reload, enable and trip output, parameterised by TIMEOUT_CYCLES).

Test Plan:
- Single-cycle units, enable=1, ready=1. Expect:
  - 5-cycle loop
  - log_start and cos_start pulse together
  - sample_cnt = 4 after 20 cycles from first RAND
- valid_u0 at cycle 2 and valid_u1 at cycle 7 of RAND. Expect LOG_COS entered the cycle after cycle 7, with one start pulse each.
- cos_done 10 cycles after sqrt_done. Expect SQRT held until cos_done, then one mult_start.
- Backpressure: sample_ready low for 500 cycles. Expect:
  - sample_valid held high throughout
  - no timeout_err
  - sample_cnt increments once when ready rises
- log_done never arrives, TIMEOUT_CYCLES=8. Expect:
  - ERR after 8 LOG_COS cycles, timeout_err=1, err_state=2
  - clear_err -> IDLE, then RAND on the next cycle
- Reset asserted mid-SQRT, and CNT_W=2 run for 5 samples. Expect:
  - mid-SQRT reset returns all outputs to 0 next edge
  - CNT_W=2 run: sample_cnt reads 1 after wrap
